// File: rtl/maxpool_stream.sv
// ============================================================================
// Module   : maxpool_stream
// Brief    : Streaming POOLxPOOL max-pooling over a raster pixel stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module maxpool_stream #(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 1,
    parameter int IN_W     = 6,
    parameter int IN_H     = 6,
    parameter int POOL     = 2,
    parameter int SIGNED   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [CHANNELS*DATA_W-1:0]   in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [CHANNELS*DATA_W-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         done
);

    localparam int c_COLS = IN_W / POOL;
    localparam int c_ROWS = IN_H / POOL;
    localparam int c_PX_W = $clog2(POOL);
    localparam int c_BX_W = (c_COLS > 1) ? $clog2(c_COLS) : 1;
    localparam int c_BY_W = (c_ROWS > 1) ? $clog2(c_ROWS) : 1;

    localparam logic [c_PX_W-1:0] c_P_LAST  = c_PX_W'(POOL - 1);
    localparam logic [c_BX_W-1:0] c_BX_LAST = c_BX_W'(c_COLS - 1);
    localparam logic [c_BY_W-1:0] c_BY_LAST = c_BY_W'(c_ROWS - 1);

    // Position is tracked as (block index, offset inside window) on each axis
    // so no divide/modulo by POOL is needed.
    logic [c_PX_W-1:0]            r_px;
    logic [c_PX_W-1:0]            r_py;
    logic [c_BX_W-1:0]            r_bx;
    logic [c_BY_W-1:0]            r_by;
    logic [CHANNELS*DATA_W-1:0]   r_acc [c_COLS];
    logic [CHANNELS*DATA_W-1:0]   r_out_data;
    logic                         r_out_valid;
    logic                         r_out_last;
    logic                         r_done;

    logic [CHANNELS*DATA_W-1:0]   w_acc_rd;
    logic [CHANNELS*DATA_W-1:0]   w_max;
    logic [CHANNELS*DATA_W-1:0]   w_acc_nxt;
    logic                         w_in_ready;
    logic                         w_fire;
    logic                         w_take;
    logic                         w_first;
    logic                         w_complete;
    logic                         w_frame_end;

    assign w_in_ready  = ~r_out_valid | out_ready;
    assign w_fire      = in_valid & w_in_ready;
    assign w_take      = r_out_valid & out_ready;
    assign w_first     = (r_px == '0) && (r_py == '0);
    assign w_complete  = (r_px == c_P_LAST) && (r_py == c_P_LAST);
    assign w_frame_end = w_complete && (r_bx == c_BX_LAST) && (r_by == c_BY_LAST);
    assign w_acc_rd    = r_acc[r_bx];
    assign w_acc_nxt   = w_first ? in_data : w_max;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_W-1:0] w_old;
        logic [DATA_W-1:0] w_new;
        logic              w_gt;

        assign w_old = w_acc_rd[c*DATA_W +: DATA_W];
        assign w_new = in_data[c*DATA_W +: DATA_W];

        if (SIGNED != 0) begin : g_signed
            assign w_gt = $signed(w_new) > $signed(w_old);
        end else begin : g_unsigned
            assign w_gt = w_new > w_old;
        end

        // Strictly-greater keeps the stored value on a tie.
        assign w_max[c*DATA_W +: DATA_W] = w_gt ? w_new : w_old;
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_acc[r_bx] <= w_acc_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_px        <= '0;
            r_py        <= '0;
            r_bx        <= '0;
            r_by        <= '0;
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= w_take & r_out_last;
            if (w_take) begin
                r_out_valid <= 1'b0;
            end
            if (w_fire) begin
                if (w_complete) begin
                    r_out_data  <= w_max;
                    r_out_valid <= 1'b1;
                    r_out_last  <= w_frame_end;
                end
                if (r_px == c_P_LAST) begin
                    r_px <= '0;
                    if (r_bx == c_BX_LAST) begin
                        r_bx <= '0;
                        if (r_py == c_P_LAST) begin
                            r_py <= '0;
                            r_by <= (r_by == c_BY_LAST) ? '0 : r_by + 1'b1;
                        end else begin
                            r_py <= r_py + 1'b1;
                        end
                    end else begin
                        r_bx <= r_bx + 1'b1;
                    end
                end else begin
                    r_px <= r_px + 1'b1;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_maxpool_stream.sv
// ============================================================================
// Module   : tb_maxpool_stream
// Brief    : Directed self-checking bench for maxpool_stream.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_maxpool_stream;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default 6x6 signed instance
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        done;

    // 2x2 single-window instances, signed and unsigned, sharing inputs
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ir, s_ov, s_ol, s_done;
    logic [7:0]  s_od;
    logic        u_ir, u_ov, u_ol, u_done;
    logic [7:0]  u_od;

    // Two-channel 4x4 instance
    logic [15:0] c_data = '0;
    logic        c_valid = 1'b0;
    logic        c_ir, c_ov, c_ol, c_done;
    logic [15:0] c_od;

    maxpool_stream dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .done(done)
    );

    maxpool_stream #(.IN_W(2), .IN_H(2), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ir),
        .out_data(s_od), .out_valid(s_ov), .out_ready(1'b1), .out_last(s_ol), .done(s_done)
    );

    maxpool_stream #(.IN_W(2), .IN_H(2), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_ready(u_ir),
        .out_data(u_od), .out_valid(u_ov), .out_ready(1'b1), .out_last(u_ol), .done(u_done)
    );

    maxpool_stream #(.CHANNELS(2), .IN_W(4), .IN_H(4)) dut_c (
        .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ir),
        .out_data(c_od), .out_valid(c_ov), .out_ready(1'b1), .out_last(c_ol), .done(c_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Output monitor for the default instance
    int         cyc = 0;
    logic [7:0] q_data[$];
    logic       q_last[$];
    int         done_cnt = 0;
    int         last_take_cyc = -10;
    int         done_cyc = -20;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                q_data.push_back(out_data);
                q_last.push_back(out_last);
                if (out_last) last_take_cyc = cyc;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        q_data.delete();
        q_last.delete();
        done_cnt = 0;
    endtask

    task automatic drive_beat(input logic [7:0] v);
        bit ok;
        int tries;
        in_data  = v;
        in_valid = 1'b1;
        tries    = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            if (ok) break;
            tries++;
            if (tries > 1000) begin
                n_errors++;
                $display("FAIL beat_timeout: in_ready stuck 0 expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drive_frame(input int offset, input bit gaps);
        for (int i = 0; i < 36; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
            #0;
            drive_beat(8'(i + offset));
        end
    endtask

    function automatic logic [7:0] exp_val(input int k, input int offset);
        return 8'(6 * (2 * (k / 3) + 1) + 2 * (k % 3) + 1 + offset);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        n_checks++;
        if (out_data !== 8'h00) begin n_errors++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
        n_checks++;
        if (out_last !== 1'b0 || done !== 1'b0) begin
            n_errors++; $display("FAIL reset_last_done: got %0b/%0b expected 0/0", out_last, done);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %0b expected 1", in_ready); end
    endtask

    task automatic test_frame();
        clear_mon();
        out_ready = 1'b1;
        drive_frame(0, 1'b0);
        repeat (4) @(posedge clk);
        n_checks++;
        if (q_data.size() != 9) begin
            n_errors++; $display("FAIL frame_count: got %0d expected 9", q_data.size());
        end
        for (int k = 0; k < 9 && k < q_data.size(); k++) begin
            n_checks++;
            if (q_data[k] !== exp_val(k, 0) || q_last[k] !== (k == 8)) begin
                n_errors++;
                $display("FAIL frame_out[%0d]: got %0d last %0b expected %0d last %0b",
                         k, q_data[k], q_last[k], exp_val(k, 0), (k == 8));
            end
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != last_take_cyc + 1) begin
            n_errors++;
            $display("FAIL frame_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, last_take_cyc + 1);
        end
    endtask

    task automatic test_backpressure();
        clear_mon();
        out_ready = 1'b0;
        fork
            drive_frame(0, 1'b0);
            begin
                int waited = 0;
                do begin
                    @(posedge clk);
                    #1;
                    waited++;
                end while (!out_valid && waited < 200);
                n_checks++;
                if (!out_valid) begin n_errors++; $display("FAIL bp_first_out: got no output expected one"); end
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    n_checks++;
                    if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== 8'd7) begin
                        n_errors++;
                        $display("FAIL bp_stall[%0d]: got ready %0b valid %0b data %0d expected 0 1 7",
                                 s, in_ready, out_valid, out_data);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        repeat (4) @(posedge clk);
        n_checks++;
        if (q_data.size() != 9) begin
            n_errors++; $display("FAIL bp_count: got %0d expected 9", q_data.size());
        end
        for (int k = 0; k < 9 && k < q_data.size(); k++) begin
            n_checks++;
            if (q_data[k] !== exp_val(k, 0)) begin
                n_errors++; $display("FAIL bp_out[%0d]: got %0d expected %0d", k, q_data[k], exp_val(k, 0));
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_mon();
        out_ready = 1'b1;
        drive_frame(0, 1'b1);
        drive_frame(-36, 1'b1);
        repeat (4) @(posedge clk);
        n_checks++;
        if (q_data.size() != 18) begin
            n_errors++; $display("FAIL b2b_count: got %0d expected 18", q_data.size());
        end
        for (int k = 0; k < 18 && k < q_data.size(); k++) begin
            logic [7:0] e;
            e = (k < 9) ? exp_val(k, 0) : exp_val(k - 9, -36);
            n_checks++;
            if (q_data[k] !== e || q_last[k] !== (k == 8 || k == 17)) begin
                n_errors++;
                $display("FAIL b2b_out[%0d]: got %0h last %0b expected %0h", k, q_data[k], q_last[k], e);
            end
        end
        n_checks++;
        if (done_cnt != 2) begin n_errors++; $display("FAIL b2b_done: got %0d expected 2", done_cnt); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) drive_beat(8'(i + 50));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_errors++; $display("FAIL rst_mid_state: got valid %0b ready %0b expected 0 1", out_valid, in_ready);
        end
        clear_mon();
        drive_frame(0, 1'b0);
        repeat (4) @(posedge clk);
        n_checks++;
        if (q_data.size() != 9) begin
            n_errors++; $display("FAIL rst_mid_count: got %0d expected 9", q_data.size());
        end
        for (int k = 0; k < 9 && k < q_data.size(); k++) begin
            n_checks++;
            if (q_data[k] !== exp_val(k, 0) || q_last[k] !== (k == 8)) begin
                n_errors++; $display("FAIL rst_mid_out[%0d]: got %0d expected %0d", k, q_data[k], exp_val(k, 0));
            end
        end
    endtask

    task automatic test_signedness();
        logic [7:0] win[4];
        logic [7:0] got_s, got_u;
        int ns, nu;
        bit ls, lu;
        win = '{8'hFF, 8'h01, 8'h80, 8'h00};
        ns = 0; nu = 0; ls = 0; lu = 0; got_s = '0; got_u = '0;
        for (int i = 0; i < 6; i++) begin
            s_valid = (i < 4);
            s_data  = (i < 4) ? win[i] : 8'h00;
            @(negedge clk);
            if (s_ov) begin ns++; got_s = s_od; ls = s_ol; end
            if (u_ov) begin nu++; got_u = u_od; lu = u_ol; end
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        n_checks++;
        if (ns != 1 || got_s !== 8'h01 || !ls) begin
            n_errors++; $display("FAIL signed_max: got %0h (n=%0d last=%0b) expected 01", got_s, ns, ls);
        end
        n_checks++;
        if (nu != 1 || got_u !== 8'hFF || !lu) begin
            n_errors++; $display("FAIL unsigned_max: got %0h (n=%0d last=%0b) expected ff", got_u, nu, lu);
        end
    endtask

    task automatic test_channels();
        logic [15:0] exp_c[4];
        logic [15:0] got[$];
        logic        gl[$];
        exp_c = '{{8'd100, 8'd5}, {8'd98, 8'd7}, {8'd92, 8'd13}, {8'd90, 8'd15}};
        for (int i = 0; i < 18; i++) begin
            c_valid = (i < 16);
            c_data  = (i < 16) ? {8'(100 - i), 8'(i)} : 16'h0;
            @(negedge clk);
            if (c_ov) begin got.push_back(c_od); gl.push_back(c_ol); end
            @(posedge clk);
            #1;
        end
        c_valid = 1'b0;
        n_checks++;
        if (got.size() != 4) begin n_errors++; $display("FAIL chan_count: got %0d expected 4", got.size()); end
        for (int k = 0; k < 4 && k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== exp_c[k] || gl[k] !== (k == 3)) begin
                n_errors++; $display("FAIL chan_out[%0d]: got %0h last %0b expected %0h", k, got[k], gl[k], exp_c[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_signedness();
        test_channels();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
